fp_addsub_pipe: RTL and testbench
=================================

Name: fp_addsub_pipe

Overview:
Parametrised, pipelined IEEE-754 adder/subtractor. It is the successor to the combinational single-precision subtractor and is used by the accumulate and bias paths of the NN accelerator datapath.
- Exponent and mantissa widths are generic.
- Per-transaction add/sub mode.
- Fixed three-stage pipeline with valid/ready handshake on both sides.
- Round-to-nearest-even, flush-to-zero on subnormals, full special-value handling, sticky-free per-result exception flags.

Parameters:
EXP_W, 8, exponent field width (>=4)
MAN_W, 23, stored mantissa field width (>=4); total word W = 1+EXP_W+MAN_W

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operand pair this cycle
in_a  input  W  operand A
in_b  input  W  operand B
in_sub  input  1  0: A+B, 1: A-B
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_result  output  W  rounded result
out_flags  output  4  {invalid, overflow, underflow, inexact} for this result

Behaviour:
- Reset (async assert, sync-released by the system) clears all stage valids. While rst_n is low: out_valid=0, out_result=0, out_flags=0, in_ready=1. A transaction in flight at reset is discarded, never emitted.
- Handshake:
  - Input transfer when in_valid&&in_ready.
  - Output transfer when out_valid&&out_ready.
  - Global stall: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - On stall, every stage holds its contents. Otherwise all stages advance.
  - Bubbles do not collapse.
  - out_result and out_flags are stable while out_valid=1 and out_ready=0.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput: 1 per cycle. Strict in-order delivery.
- Stage 1, unpack/compare:
  - Effective B sign = b.sign ^ in_sub.
  - Exponent field 0 means zero (subnormals flushed to signed zero, no flag). All-ones with mantissa 0 means inf; all-ones with mantissa !=0 means NaN.
  - Swap so the larger magnitude is operand X.
  - exp_diff = eX - eY.
- Stage 2, align/add:
  - Shift Y's significand (hidden 1 restored) right by exp_diff, keeping guard, round and sticky bits. A shift >= MAN_W+3 leaves only sticky.
  - Add if effective signs match, else subtract (X-Y, never negative).
  - Result sign = X sign.
- Stage 3, normalise/round/pack:
  - On carry-out: shift right 1 and exp+1.
  - Otherwise: leading-zero count, shift left, exp minus count.
  - RNE on guard/round/sticky. Rounding carry renormalises.
- Exact-zero result:
  - +0, except -0 when both effective operands are negative zeros.
  - Result +0 for x-x of equal magnitude.
- Overflow (biased exp >= 2^EXP_W-1 after rounding): signed inf; flags overflow+inexact.
- Underflow (biased exp <= 0 after normalise): signed zero; flags underflow+inexact.
- Special values:
  - Any NaN in gives canonical qNaN (sign 0, exp all-ones, mantissa MSB 1, rest 0). invalid=1 only if an input is an sNaN (mantissa MSB 0).
  - inf + (-inf) effective gives canonical qNaN, invalid=1.
  - inf op finite gives that inf, no flags.
  - Same-signed infs give that inf.
- inexact=1 whenever any discarded guard/round/sticky bit was non-zero, or on overflow/underflow.

Test Plan:
- Basic: a=0x41000000, b=0x40800000, sub=1 -> out_result 0x40800000, flags 0, exactly 3 cycles after transfer. Then 0xC1200000 - 0xC0000000 -> 0xC1000000. Then 0x3FC00000 - 0x3FC00000 -> 0x00000000.
- Rounding: 0x3F800000 + 0x33800000 (sub=0) -> 0x3F800000, inexact=1 (tie to even). 0x3F800001 + 0x33800000 -> 0x3F800002, inexact=1.
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags overflow|inexact.
  - 0x7F800000 - 0x7F800000 -> 0x7FC00000, invalid=1.
  - 0x7F800001 + 0x3F800000 -> 0x7FC00000, invalid=1.
  - 0x00000001 + 0x00000000 -> 0x00000000, flags 0.
- Backpressure: stream 5 back-to-back ops with out_ready=0 from cycle 2 for 4 cycles. in_ready drops in the first stalled cycle; all 5 results appear in order with no loss or duplication, and out_result is stable during the stall.
- Reset mid-flight: issue 2 ops, assert rst_n=0 for 1 cycle before either emerges. out_valid=0 immediately (asynchronous) and no stale result appears after release. A new op then completes in 3 cycles.
- Parameter sweep: EXP_W=5, MAN_W=10 (half precision): 0x4800 - 0x4400 -> 0x4400; 0x7BFF + 0x7BFF -> 0x7C00 with overflow.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 adder/subtractor with generic exponent/mantissa widths.
// Stages: unpack/swap -> align/add -> normalise/round/pack. RNE rounding, subnormals flushed to zero.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic                 in_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic [3:0]           out_flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;  // hidden bit + mantissa + guard/round/sticky
  localparam int LZW = $clog2(SW + 1);
  localparam int EW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE  = EW'(1);

  // Valid/ready: a word crosses a port only when valid and ready are both high. The whole
  // pipe freezes while the output word is valid but not accepted; in_ready is the inverse.
  logic stall, adv;
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  // ---------------- stage 1: unpack, classify, order by magnitude
  logic sa, sb, za, zb, ia, ib, na, nb, swap;
  logic [EXP_W+MAN_W-1:0] mag_a, mag_b, mag_x, mag_y;
  logic [W-1:0] spec_res;
  logic spec_inv;

  assign sa    = in_a[W-1];
  assign sb    = in_b[W-1] ^ in_sub;
  assign za    = in_a[W-2 -: EXP_W] == '0;
  assign zb    = in_b[W-2 -: EXP_W] == '0;
  assign ia    = (in_a[W-2 -: EXP_W] == '1) && (in_a[MAN_W-1:0] == '0);
  assign ib    = (in_b[W-2 -: EXP_W] == '1) && (in_b[MAN_W-1:0] == '0);
  assign na    = (in_a[W-2 -: EXP_W] == '1) && (in_a[MAN_W-1:0] != '0);
  assign nb    = (in_b[W-2 -: EXP_W] == '1) && (in_b[MAN_W-1:0] != '0);
  assign mag_a = za ? '0 : in_a[W-2:0];
  assign mag_b = zb ? '0 : in_b[W-2:0];
  assign swap  = mag_b > mag_a;
  assign mag_x = swap ? mag_b : mag_a;
  assign mag_y = swap ? mag_a : mag_b;

  always_comb begin
    spec_res = QNAN;
    spec_inv = 1'b0;
    if (na | nb)
      spec_inv = (na & ~in_a[MAN_W-1]) | (nb & ~in_b[MAN_W-1]);
    else if (ia & ib & (sa ^ sb))
      spec_inv = 1'b1;
    else if (ia)
      spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (ib)
      spec_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  logic v1, s1_spec, s1_inv, s1_sign, s1_sub, s1_negz;
  logic [W-1:0] s1_spec_res;
  logic [EXP_W-1:0] s1_exp, s1_diff;
  logic [MAN_W:0] s1_sigx, s1_sigy;

  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      s1_spec     <= na | nb | ia | ib;
      s1_inv      <= spec_inv;
      s1_spec_res <= spec_res;
      s1_sign     <= swap ? sb : sa;
      s1_sub      <= sa ^ sb;
      s1_negz     <= za & zb & sa & sb;
      s1_exp      <= mag_x[EXP_W+MAN_W-1 -: EXP_W];
      s1_diff     <= mag_x[EXP_W+MAN_W-1 -: EXP_W] - mag_y[EXP_W+MAN_W-1 -: EXP_W];
      s1_sigx     <= {mag_x[EXP_W+MAN_W-1 -: EXP_W] != '0, mag_x[MAN_W-1:0]};
      s1_sigy     <= {mag_y[EXP_W+MAN_W-1 -: EXP_W] != '0, mag_y[MAN_W-1:0]};
    end
  end

  // ---------------- stage 2: align smaller operand, add or subtract
  logic [SW-1:0] x_ext, y_ext, y_sh;
  logic [2*SW-1:0] y_wide;
  logic [SW:0] sum;

  assign x_ext  = {s1_sigx, 3'b000};
  assign y_ext  = {s1_sigy, 3'b000};
  assign y_wide = {y_ext, {SW{1'b0}}} >> s1_diff;
  assign y_sh   = (int'(s1_diff) >= SW) ? {{(SW-1){1'b0}}, |y_ext}
                                        : {y_wide[2*SW-1:SW+1], y_wide[SW] | (|y_wide[SW-1:0])};
  assign sum    = s1_sub ? ({1'b0, x_ext} - {1'b0, y_sh}) : ({1'b0, x_ext} + {1'b0, y_sh});

  logic v2, s2_spec, s2_inv, s2_sign, s2_negz;
  logic [W-1:0] s2_spec_res;
  logic [EXP_W-1:0] s2_exp;
  logic [SW:0] s2_sum;

  always_ff @(posedge clk) begin
    if (adv && v1) begin
      s2_spec     <= s1_spec;
      s2_inv      <= s1_inv;
      s2_spec_res <= s1_spec_res;
      s2_sign     <= s1_sign;
      s2_negz     <= s1_negz;
      s2_exp      <= s1_exp;
      s2_sum      <= sum;
    end
  end

  // ---------------- stage 3: normalise, round to nearest even, pack
  function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
    lzc = LZW'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) lzc = LZW'(SW - 1 - i);
  endfunction

  logic [LZW-1:0] lz;
  logic [SW-1:0] norm;
  logic signed [EW-1:0] e_x, lz_s, e_n, e_r;
  logic [MAN_W+1:0] mr;
  logic [MAN_W-1:0] frac;
  logic g, rb, st, rup;
  logic [W-1:0] res;
  logic [3:0] flg;

  assign lz   = lzc(s2_sum[SW-1:0]);
  assign e_x  = signed'({{(EW-EXP_W){1'b0}}, s2_exp});
  assign lz_s = signed'({{(EW-LZW){1'b0}}, lz});
  assign norm = s2_sum[SW] ? {s2_sum[SW:2], s2_sum[1] | s2_sum[0]} : (s2_sum[SW-1:0] << lz);
  assign e_n  = s2_sum[SW] ? (e_x + ONE) : (e_x - lz_s);
  assign g    = norm[2];
  assign rb   = norm[1];
  assign st   = norm[0];
  assign rup  = g & (rb | st | norm[3]);
  assign mr   = {1'b0, norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, rup};
  assign e_r  = mr[MAN_W+1] ? (e_n + ONE) : e_n;
  assign frac = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];

  always_comb begin
    res = {s2_sign, e_r[EXP_W-1:0], frac};
    flg = {3'b000, g | rb | st};
    if (s2_spec) begin
      res = s2_spec_res;
      flg = {s2_inv, 3'b000};
    end else if (s2_sum == '0) begin
      res = {s2_negz, {(W-1){1'b0}}};
      flg = 4'b0000;
    end else if (e_n[EW-1] || (e_n == '0)) begin
      res = {s2_sign, {(W-1){1'b0}}};
      flg = 4'b0011;
    end else if (e_r >= EMAX) begin
      res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg = 4'b0101;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        out_result <= res;
        out_flags  <= flg;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: single precision plus a half-precision instance,
// scoreboard queues filled by the drivers and drained by per-DUT output monitors.
module tb_fp_addsub_pipe;
  localparam int W   = 32;
  localparam int RW  = W + 4;
  localparam int HW  = 16;
  localparam int HRW = HW + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b, out_result;
  logic [3:0]    out_flags;
  logic          h_in_valid, h_in_ready, h_in_sub, h_out_valid, h_out_ready;
  logic [HW-1:0] h_in_a, h_in_b, h_out_result;
  logic [3:0]    h_out_flags;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
  );

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_a(h_in_a), .in_b(h_in_b), .in_sub(h_in_sub), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .out_result(h_out_result), .out_flags(h_out_flags)
  );

  // Expected {result, flags}; lat_q holds the presentation cycle, or -1 for no latency check.
  logic [RW-1:0]  exp_q[$];
  int             lat_q[$];
  logic [HRW-1:0] hexp_q[$];
  int tests = 0;
  int fails = 0;
  int mon_lt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Directed vectors: a, b, sub, expected {result, flags}
  localparam int NV = 16;
  logic [31:0] va [NV] = '{32'h41000000, 32'hC1200000, 32'h3FC00000, 32'h3F800000,
                           32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800001,
                           32'h00000001, 32'h80000000, 32'h3F800000, 32'h00800001,
                           32'hFF800000, 32'h7FC00000, 32'h3F800000, 32'h3F7FFFFF};
  logic [31:0] vb [NV] = '{32'h40800000, 32'hC0000000, 32'h3FC00000, 32'h33800000,
                           32'h33800000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000,
                           32'h00000000, 32'h00000000, 32'h3F7FFFFF, 32'h00800000,
                           32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h33000000};
  logic        vs [NV] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                           1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [35:0] ve [NV] = '{36'h40800000_0, 36'hC1000000_0, 36'h00000000_0, 36'h3F800000_1,
                           36'h3F800002_1, 36'h7F800000_5, 36'h7FC00000_8, 36'h7FC00000_8,
                           36'h00000000_0, 36'h80000000_0, 36'h33800000_0, 36'h00000000_3,
                           36'hFF800000_0, 36'h7FC00000_0, 36'h40000000_0, 36'h3F800000_1};

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [35:0] exp_v, input logic chk, input logic track);
    int waits;
    waits = 0;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    while (!in_ready && waits < 50) begin
      @(posedge clk); #2;
      waits++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, waits);
    end else if (track) begin
      exp_q.push_back(exp_v);
      lat_q.push_back(chk ? cyc : -1);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic issue_h(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic [19:0] exp_v);
    int waits;
    waits = 0;
    h_in_a = a; h_in_b = b; h_in_sub = sub; h_in_valid = 1'b1;
    while (!h_in_ready && waits < 50) begin
      @(posedge clk); #2;
      waits++;
    end
    if (!h_in_ready) begin
      tests++; fails++;
      $display("FAIL h_in_ready_timeout: h_in_ready=%0b, expected 1", h_in_ready);
    end else hexp_q.push_back(exp_v);
    @(posedge clk); #2;
    h_in_valid = 1'b0;
  endtask

  // Main monitor: pop on transfer, check stability against the head while stalled.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out: got 0x%0h/%0h, expected no output", out_result, out_flags);
      end else if (out_ready) begin
        check("result", {out_result, out_flags}, exp_q.pop_front());
        mon_lt = lat_q.pop_front();
        if (mon_lt >= 0) check("latency", cyc - mon_lt, 3);
      end else begin
        check("hold", {out_result, out_flags}, exp_q[0]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && h_out_valid) begin
      if (hexp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL h_unexpected_out: got 0x%0h, expected no output", h_out_result);
      end else if (h_out_ready) begin
        check("h_result", {h_out_result, h_out_flags}, hexp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_in_sub = 1'b0; h_out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", out_flags, 0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Directed vectors back to back, latency checked on each
    for (int i = 0; i < NV; i++) issue(va[i], vb[i], vs[i], ve[i], 1'b1, 1'b1);
    repeat (6) @(posedge clk);
    #2;
    check("drain_directed", exp_q.size(), 0);

    // Backpressure: 5 ops streamed, output stalled for 4 cycles
    fork
      begin
        for (int i = 0; i < 5; i++) issue(va[i], vb[i], vs[i], ve[i], 1'b0, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #2;
    check("drain_backpressure", exp_q.size(), 0);

    // Reset with two ops in flight; neither may be emitted
    issue(va[3], vb[3], vs[3], ve[3], 1'b0, 1'b0);
    issue(va[5], vb[5], vs[5], ve[5], 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_out_result", out_result, 0);
    check("rst_mid_out_flags", out_flags, 0);
    check("rst_mid_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    issue(va[14], vb[14], vs[14], ve[14], 1'b1, 1'b1);
    repeat (6) @(posedge clk);
    #2;
    check("drain_after_reset", exp_q.size(), 0);

    // Half precision instance
    issue_h(16'h4800, 16'h4400, 1'b1, 20'h4400_0);
    issue_h(16'h7BFF, 16'h7BFF, 1'b0, 20'h7C00_5);
    issue_h(16'h3C00, 16'h3C00, 1'b0, 20'h4000_0);
    repeat (6) @(posedge clk);
    #2;
    check("drain_half", hexp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
